// File: rtl/huff_pkg.sv
// Shared types and constants for the canonical-Huffman stream decoder.
//   huff_state_t : controller states (IDLE, CALC, RUN)
//   DEF_*        : default parameter values
//   width_of()   : index width for n distinct values, never below 1
package huff_pkg;

  typedef enum logic [1:0] {IDLE, CALC, RUN} huff_state_t;

  localparam int DEF_SYM_W      = 8;
  localparam int DEF_MAX_LEN    = 12;
  localparam int DEF_NUM_SYMS   = 256;
  localparam int DEF_FIFO_DEPTH = 4;

  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/huff_out_fifo.sv
// Output symbol FIFO for the Huffman decoder.
//   clk, rst        : clock, synchronous active-high reset (empties the FIFO)
//   push, wr_data   : write side (ignored when full)
//   pop, rd_data    : read side; rd_data is the head, forced to 0 when empty
//   full, empty     : status
//   count           : registered occupancy
module huff_out_fifo
  import huff_pkg::*;
#(
  parameter int W     = DEF_SYM_W,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [W-1:0]                  wr_data,
  input  logic                          pop,
  output logic [W-1:0]                  rd_data,
  output logic                          full,
  output logic                          empty,
  output logic [width_of(DEPTH+1)-1:0]  count
);

  localparam int AW = width_of(DEPTH);
  localparam int OW = width_of(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == OW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Head is masked so the output reads 0 out of reset without clearing mem.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + OW'(1);
        2'b01:   count <= count - OW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/huff_stream_decoder.sv
// Bit-serial canonical-Huffman decoder with runtime-loaded code table.
//   clk, rst                         : clock, synchronous active-high reset
//   serial_in/valid/ready            : compressed bit stream, MSB of code first
//   cfg_cnt_we, cfg_len, cfg_cnt     : per-length code count writes
//   cfg_sym_we, cfg_sym_idx, cfg_sym : canonical symbol list writes
//   cfg_commit                       : rebuild first[]/base[] from the counts
//   ext_char/ext_en/ext_ready        : decoded symbol stream (FIFO head)
//   table_ok                         : table built and decoding (RUN)
//   table_err                        : sticky oversubscribed-table flag
//   code_err                         : one-cycle pulse, MAX_LEN bits with no match
module huff_stream_decoder
  import huff_pkg::*;
#(
  parameter int SYM_W      = DEF_SYM_W,
  parameter int MAX_LEN    = DEF_MAX_LEN,
  parameter int NUM_SYMS   = DEF_NUM_SYMS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              serial_in,
  input  logic                              serial_valid,
  output logic                              serial_ready,
  input  logic                              cfg_cnt_we,
  input  logic [width_of(MAX_LEN+1)-1:0]    cfg_len,
  input  logic [width_of(NUM_SYMS+1)-1:0]   cfg_cnt,
  input  logic                              cfg_sym_we,
  input  logic [width_of(NUM_SYMS)-1:0]     cfg_sym_idx,
  input  logic [SYM_W-1:0]                  cfg_sym,
  input  logic                              cfg_commit,
  output logic [SYM_W-1:0]                  ext_char,
  output logic                              ext_en,
  input  logic                              ext_ready,
  output logic                              table_ok,
  output logic                              table_err,
  output logic                              code_err
);

  localparam int LW    = width_of(MAX_LEN+1);
  localparam int CNT_W = width_of(NUM_SYMS+1);
  localparam int IDX_W = width_of(NUM_SYMS);
  localparam int CW    = MAX_LEN + 1;
  localparam int OCC_W = width_of(FIFO_DEPTH+1);

  huff_state_t state, state_nxt;

  // count_cfg collects writes; count_act is the table the decoder uses and
  // is only refreshed on commit, so count writes during RUN stay invisible
  // until the next build. Index 0 is never written and reads as 0.
  logic [CNT_W-1:0] count_cfg [MAX_LEN+1];
  logic [CNT_W-1:0] count_act [MAX_LEN+1];
  logic [CW-1:0]    first_r   [MAX_LEN+1];
  logic [CW-1:0]    base_r    [MAX_LEN+1];
  logic [SYM_W-1:0] symtab    [NUM_SYMS];

  logic [LW-1:0]        calc_l, calc_prev;
  logic [CW-1:0]        first_l, base_l;
  logic                 calc_over;
  logic [MAX_LEN-2:0]   code;
  logic [LW-1:0]        len;
  logic [MAX_LEN-1:0]   new_code;
  logic [LW-1:0]        new_len;
  logic [CW-1:0]        code_ext, diff, idx_full;
  logic                 hit, at_max, accept, take_commit, cfg_en, push;
  logic [IDX_W-1:0]     sym_idx;
  logic                 fifo_full, fifo_empty;
  logic [OCC_W-1:0]     fifo_cnt;

  assign cfg_en      = (state != CALC);
  assign take_commit = cfg_commit && cfg_en;
  assign serial_ready = (state == RUN) && (fifo_cnt < OCC_W'(FIFO_DEPTH));
  assign accept      = serial_valid && serial_ready;
  assign table_ok    = (state == RUN);
  assign ext_en      = !fifo_empty;

  // ---- table build: one code length per CALC cycle ----
  assign calc_prev = calc_l - LW'(1);
  always_comb begin
    first_l = '0;
    base_l  = '0;
    if (calc_l != LW'(1)) begin
      first_l = (first_r[calc_prev] + CW'(count_cfg[calc_prev])) << 1;
      base_l  = base_r[calc_prev] + CW'(count_cfg[calc_prev]);
    end
    calc_over = (first_l + CW'(count_cfg[calc_l])) > (CW'(1) << calc_l);
  end

  // ---- decode: extend the code by one bit and test against length len+1 ----
  assign new_code = {code, serial_in};
  assign new_len  = len + LW'(1);
  assign code_ext = CW'(new_code);
  assign diff     = code_ext - first_r[new_len];
  // A code below first[] would wrap diff to a large value; the explicit
  // compare keeps that case a miss even for pathological counts.
  assign hit      = (code_ext >= first_r[new_len]) && (diff < CW'(count_act[new_len]));
  assign at_max   = (new_len == LW'(MAX_LEN));
  assign idx_full = base_r[new_len] + diff;
  assign sym_idx  = IDX_W'(idx_full % CW'(NUM_SYMS));
  // A commit in the same cycle wins: the in-flight bit is dropped.
  assign push     = accept && hit && !take_commit;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cfg_commit) state_nxt = CALC;
      CALC: begin
        if (calc_over)                     state_nxt = IDLE;
        else if (calc_l == LW'(MAX_LEN))   state_nxt = RUN;
      end
      RUN:  if (cfg_commit) state_nxt = CALC;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= MAX_LEN; i++) begin
        count_cfg[i] <= '0;
        count_act[i] <= '0;
        first_r[i]   <= '0;
        base_r[i]    <= '0;
      end
      calc_l    <= '0;
      code      <= '0;
      len       <= '0;
      table_err <= 1'b0;
      code_err  <= 1'b0;
    end else begin
      code_err <= 1'b0;
      if (cfg_en && cfg_cnt_we && cfg_len != '0 && cfg_len <= LW'(MAX_LEN))
        count_cfg[cfg_len] <= cfg_cnt;
      if (take_commit) begin
        for (int i = 0; i <= MAX_LEN; i++) count_act[i] <= count_cfg[i];
        calc_l    <= LW'(1);
        table_err <= 1'b0;
        code      <= '0;
        len       <= '0;
      end else if (state == CALC) begin
        first_r[calc_l] <= first_l;
        base_r[calc_l]  <= base_l;
        calc_l          <= calc_l + LW'(1);
        if (calc_over) table_err <= 1'b1;
      end else if (accept) begin
        if (hit || at_max) begin
          code     <= '0;
          len      <= '0;
          code_err <= !hit;
        end else begin
          code <= new_code[MAX_LEN-2:0];
          len  <= new_len;
        end
      end
    end
  end

  // Symbol list is deliberately not reset; it survives rst.
  always_ff @(posedge clk) begin
    if (cfg_en && cfg_sym_we) symtab[cfg_sym_idx] <= cfg_sym;
  end

  huff_out_fifo #(.W(SYM_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push && !fifo_full),
    .wr_data (symtab[sym_idx]),
    .pop     (ext_ready),
    .rd_data (ext_char),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

endmodule

// File: tb/tb_huff_stream_decoder.sv
module tb_huff_stream_decoder;
  import huff_pkg::*;

  localparam int MAX_LEN = 12;

  logic       tb_clk = 1'b0;
  logic       rst = 1'b1;
  logic       serial_in = 1'b0, serial_valid = 1'b0, serial_ready;
  logic       cfg_cnt_we = 1'b0, cfg_sym_we = 1'b0, cfg_commit = 1'b0;
  logic [3:0] cfg_len = '0;
  logic [8:0] cfg_cnt = '0;
  logic [7:0] cfg_sym_idx = '0, cfg_sym = '0;
  logic [7:0] ext_char;
  logic       ext_en, ext_ready = 1'b0;
  logic       table_ok, table_err, code_err;

  int checks = 0, errors = 0;
  logic [7:0] exp_q [$];

  always #5 tb_clk = ~tb_clk;

  huff_stream_decoder dut (
    .clk(tb_clk), .rst(rst),
    .serial_in(serial_in), .serial_valid(serial_valid), .serial_ready(serial_ready),
    .cfg_cnt_we(cfg_cnt_we), .cfg_len(cfg_len), .cfg_cnt(cfg_cnt),
    .cfg_sym_we(cfg_sym_we), .cfg_sym_idx(cfg_sym_idx), .cfg_sym(cfg_sym),
    .cfg_commit(cfg_commit),
    .ext_char(ext_char), .ext_en(ext_en), .ext_ready(ext_ready),
    .table_ok(table_ok), .table_err(table_err), .code_err(code_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  // Scoreboard: every pop the sink performs must match the oldest expected symbol.
  always @(negedge tb_clk) begin
    if (!rst && ext_en && ext_ready) begin
      if (exp_q.size() == 0) check("sb_unexpected_pop", {24'd0, ext_char}, 32'hFFFF_FFFF);
      else check("sb_sym", {24'd0, ext_char}, {24'd0, exp_q.pop_front()});
    end
  end

  task automatic set_cnt(input int l, input int c);
    cfg_cnt_we = 1'b1; cfg_len = 4'(l); cfg_cnt = 9'(c);
    tick();
    cfg_cnt_we = 1'b0;
  endtask

  task automatic set_sym(input int i, input int s);
    cfg_sym_we = 1'b1; cfg_sym_idx = 8'(i); cfg_sym = 8'(s);
    tick();
    cfg_sym_we = 1'b0;
  endtask

  // Commit and return the cycle count until table_ok or table_err.
  task automatic commit_wait(output int n);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    n = 1;
    while (!table_ok && !table_err && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic load_table_a();
    set_cnt(1, 1); set_cnt(2, 1); set_cnt(3, 2);
    set_sym(0, 8'h41); set_sym(1, 8'h42); set_sym(2, 8'h43); set_sym(3, 8'h44);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    exp_q.delete();
    rst = 1'b0;
  endtask

  // Drive one bit, waiting (bounded) for serial_ready.
  task automatic send_bit(input logic b);
    int n;
    serial_valid = 1'b1; serial_in = b;
    n = 0;
    while (!serial_ready && n < 20) begin tick(); n++; end
    if (n == 20) check("send_timeout", 32'd0, 32'd1);
    tick();
    serial_valid = 1'b0;
  endtask

  typedef struct { logic b; logic push; logic [7:0] sym; } vec_t;
  vec_t vecs [16];

  initial begin
    int n, acc, pulses, last_at, ext_seen;

    // 0 10 110 111 | 0 0 111 10
    vecs = '{
      '{1'b0, 1'b1, 8'h41}, '{1'b1, 1'b0, 8'h00}, '{1'b0, 1'b1, 8'h42},
      '{1'b1, 1'b0, 8'h00}, '{1'b1, 1'b0, 8'h00}, '{1'b0, 1'b1, 8'h43},
      '{1'b1, 1'b0, 8'h00}, '{1'b1, 1'b0, 8'h00}, '{1'b1, 1'b1, 8'h44},
      '{1'b0, 1'b1, 8'h41}, '{1'b0, 1'b1, 8'h41}, '{1'b1, 1'b0, 8'h00},
      '{1'b1, 1'b0, 8'h00}, '{1'b1, 1'b1, 8'h44}, '{1'b1, 1'b0, 8'h00},
      '{1'b0, 1'b1, 8'h42}
    };

    // ---- reset ----
    do_reset();
    check("rst_serial_ready", serial_ready, 0);
    check("rst_ext_en", ext_en, 0);
    check("rst_ext_char", ext_char, 0);
    check("rst_table_ok", table_ok, 0);
    check("rst_table_err", table_err, 0);
    check("rst_code_err", code_err, 0);
    serial_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      if (serial_ready) n++;
      tick();
    end
    serial_valid = 1'b0;
    check("idle_ready_cycles", n, 0);

    // ---- table load, commit latency ----
    load_table_a();
    check("pre_commit_ready", serial_ready, 0);
    commit_wait(n);
    check("commit_latency", n, MAX_LEN + 1);
    check("table_ok_up", table_ok, 1);

    // ---- table-driven decode with ext_ready high ----
    ext_ready = 1'b1;
    foreach (vecs[i]) begin
      serial_valid = 1'b1; serial_in = vecs[i].b;
      check("vec_ready", serial_ready, 1);
      if (vecs[i].push) exp_q.push_back(vecs[i].sym);
      tick();
      check($sformatf("vec%0d_en", i), ext_en, vecs[i].push);
      if (vecs[i].push) check($sformatf("vec%0d_sym", i), ext_char, vecs[i].sym);
    end
    serial_valid = 1'b0;
    tick();

    // ---- backpressure ----
    ext_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      serial_valid = 1'b1; serial_in = 1'b0;
      if (serial_ready) begin acc++; exp_q.push_back(8'h41); end
      tick();
    end
    serial_valid = 1'b0;
    check("bp_accepted", acc, 4);
    check("bp_ready_low", serial_ready, 0);
    check("bp_head", ext_char, 8'h41);
    ext_ready = 1'b1;
    n = 0;
    while (ext_en && n < 20) begin tick(); n++; end
    check("bp_drain_cycles", n, 4);
    check("bp_ready_back", serial_ready, 1);

    // ---- oversubscription, then clear by recommit ----
    set_cnt(1, 3);
    check("run_cnt_write_hidden", table_ok, 1);
    commit_wait(n);
    check("over_err", table_err, 1);
    check("over_cycles", n, 2);
    tick();
    check("over_table_ok", table_ok, 0);
    check("over_ready", serial_ready, 0);
    set_cnt(1, 1);
    check("err_sticky", table_err, 1);
    commit_wait(n);
    check("err_cleared", table_err, 0);
    check("recommit_ok", table_ok, 1);

    // ---- code error: only a 1-bit code "0" exists ----
    do_reset();
    set_cnt(1, 1);
    set_sym(0, 8'h41);
    commit_wait(n);
    check("ce_table_ok", table_ok, 1);
    pulses = 0; last_at = 0; ext_seen = 0;
    for (int i = 1; i <= 13; i++) begin
      serial_valid = (i <= 12); serial_in = 1'b1;
      tick();
      if (code_err) begin pulses++; last_at = i; end
      if (ext_en) ext_seen++;
    end
    check("ce_pulses", pulses, 1);
    check("ce_pulse_at", last_at, 12);
    check("ce_no_push", ext_seen, 0);
    exp_q.push_back(8'h41);
    serial_valid = 1'b1; serial_in = 1'b0;
    tick();
    serial_valid = 1'b0;
    check("ce_after_en", ext_en, 1);
    check("ce_after_sym", ext_char, 8'h41);
    tick();

    // ---- mid-stream reset ----
    do_reset();
    load_table_a();
    commit_wait(n);
    ext_ready = 1'b0;
    send_bit(1'b0);   // parked in FIFO, must be lost on reset
    send_bit(1'b1);
    send_bit(1'b1);
    check("mr_fifo_pre", ext_en, 1);
    rst = 1'b1;
    tick();
    exp_q.delete();
    rst = 1'b0;
    check("mr_fifo_empty", ext_en, 0);
    check("mr_idle", table_ok, 0);
    check("mr_ready", serial_ready, 0);
    ext_ready = 1'b1;
    load_table_a();
    commit_wait(n);
    check("mr_commit_latency", n, MAX_LEN + 1);
    exp_q.push_back(8'h41);
    serial_valid = 1'b1; serial_in = 1'b0;
    tick();
    serial_valid = 1'b0;
    check("mr_en", ext_en, 1);
    check("mr_sym", ext_char, 8'h41);
    tick(); tick();
    check("mr_single_symbol", ext_en, 0);

    check("sb_leftover", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
